instr_scheduler: RTL and testbench

Instruction issue scheduler between the host command interface and the TPU control FSM. It buffers host instructions in a DEPTH-entry FIFO. It issues one instruction at a time to the controller using an `s_update` pulse, then tracks the controller through busy and back to idle before issuing the next. It also provides flush, watchdog error and completion-count observability.

---
 rtl/instr_scheduler.sv | 163 ++++++++++++++++
 tb/tb_instr_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : instr_scheduler
// Description : Buffers host instructions in a FIFO and issues them one at a
//               time to the TPU controller, with a watchdog and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_scheduler #(
    parameter  int N       = 4,
    parameter  int K       = 8,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 64,
    localparam int IW      = 3 + $clog2(K),
    localparam int c_AW    = $clog2(DEPTH),
    localparam int c_CW    = c_AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            host_valid,
    input  logic [IW-1:0]   host_instr,
    output logic            host_ready,
    input  logic            flush,
    input  logic            ctrl_idle,
    output logic            s_update,
    output logic [IW-1:0]   issue_instr,
    output logic            busy,
    output logic [c_CW-1:0] fifo_count,
    output logic [15:0]     done_count,
    output logic            err
);

    localparam int c_WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     mem_q [DEPTH];
    logic [c_AW-1:0]   wptr_q, rptr_q;
    logic [c_CW-1:0]   count_q;
    logic [IW-1:0]     issue_q;
    logic [15:0]       done_q;
    logic              err_q;
    logic [c_WW-1:0]   wd_q, wd_d;

    logic w_push;
    logic w_start;
    logic w_err_set;
    logic w_done_inc;

    // host_ready comes from the registered count, so a same-cycle pop never
    // opens a slot in a full FIFO.
    assign host_ready = (count_q != c_CW'(DEPTH));
    assign w_push     = host_valid && host_ready && !flush;
    assign w_start    = (state_q == S_IDLE) && (count_q != '0) && ctrl_idle && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= host_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_start) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_q + c_CW'(w_push) - c_CW'(w_start);
        end
    end

    always_comb begin
        state_d    = state_q;
        w_err_set  = 1'b0;
        w_done_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!ctrl_idle) begin
                    state_d = S_WAIT_DONE;
                end else if (wd_q >= c_WW'(1)) begin
                    state_d   = S_IDLE;
                    w_err_set = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (ctrl_idle) begin
                    state_d    = S_IDLE;
                    w_done_inc = 1'b1;
                end else if (wd_q >= c_WW'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    w_err_set = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Watchdog restarts on every state change and saturates otherwise.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (wd_q != c_WW'(TIMEOUT)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            issue_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (w_start) begin
                issue_q <= mem_q[rptr_q];
            end
            if (w_done_inc) begin
                done_q <= done_q + 16'd1;
            end
            if (w_err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign s_update    = (state_q == S_ISSUE);
    assign issue_instr = issue_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count  = count_q;
    assign done_count  = done_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_scheduler
// Description : Scoreboard bench for instr_scheduler with a controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_scheduler;

    localparam int IW    = 6;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_valid;
    logic [IW-1:0] host_instr;
    logic          host_ready;
    logic          flush;
    logic          ctrl_idle;
    logic          s_update;
    logic [IW-1:0] issue_instr;
    logic          busy;
    logic [3:0]    fifo_count;
    logic [15:0]   done_count;
    logic          err;

    instr_scheduler #(.N(4), .K(8), .DEPTH(DEPTH), .TIMEOUT(64)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_instr (host_instr),
        .host_ready (host_ready),
        .flush      (flush),
        .ctrl_idle  (ctrl_idle),
        .s_update   (s_update),
        .issue_instr(issue_instr),
        .busy       (busy),
        .fifo_count (fifo_count),
        .done_count (done_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            n_issued = 0;
    int            exp_done = 0;
    logic [IW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bound_fail(input string name, input int bound);
        n_checks++;
        $display("FAIL %s: event not seen within %0d cycles, expected it (cycle %0d)", name, bound, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Controller model: after sampling s_update it stays busy busy_len cycles.
    int busy_len   = 2;
    int busy_left  = 0;
    bit ignore_su  = 1'b0;
    bit force_busy = 1'b0;
    initial ctrl_idle = 1'b1;

    always @(negedge clk) begin
        if (rst_n && s_update && !ignore_su) busy_left = busy_len;
    end

    always @(posedge clk) begin
        #1;
        if (busy_left > 0) begin
            ctrl_idle = 1'b0;
            busy_left--;
        end else begin
            ctrl_idle = !force_busy;
        end
    end

    // Reference FIFO: entries the host has handed over and not yet issued.
    always @(posedge clk) begin
        if (!rst_n || flush) exp_q.delete();
        else if (host_valid && exp_q.size() != DEPTH) exp_q.push_back(host_instr);
    end

    bit su_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            su_prev = 1'b0;
        end else begin
            if (s_update) begin
                check("s_update_one_cycle", {31'd0, su_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL issue_unexpected: got issue 0x%0h, expected no issue (cycle %0d)", issue_instr, cyc);
                end else begin
                    check("issue_order", {26'd0, issue_instr}, {26'd0, exp_q.pop_front()});
                end
                n_issued++;
            end
            su_prev = s_update;
            check("fifo_count", {28'd0, fifo_count}, exp_q.size());
            check("host_ready", {31'd0, host_ready}, {31'd0, exp_q.size() != DEPTH});
            if (exp_q.size() != 0) check("busy_nonempty", {31'd0, busy}, 32'd1);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [IW-1:0] v);
        host_valid = 1'b1;
        host_instr = v;
        tick();
        host_valid = 1'b0;
    endtask

    // Returns at the negedge where s_update is seen; cycle index of the issue edge.
    task automatic wait_issue(input string name, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (s_update) begin
                at = cyc;
                return;
            end
        end
        bound_fail(name, bound);
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        bound_fail(name, bound);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_update"},    {31'd0, s_update},    32'd0);
        check({tag, "_issue_instr"}, {26'd0, issue_instr}, 32'd0);
        check({tag, "_host_ready"},  {31'd0, host_ready},  32'd1);
        check({tag, "_busy"},        {31'd0, busy},        32'd0);
        check({tag, "_fifo_count"},  {28'd0, fifo_count},  32'd0);
        check({tag, "_done_count"},  {16'd0, done_count},  32'd0);
        check({tag, "_err"},         {31'd0, err},         32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e0, t, prev, t_first, snap;
        rst_n      = 1'b0;
        host_valid = 1'b0;
        host_instr = '0;
        flush      = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick();
        check_reset_outputs("reset");

        // Single instruction: issue one cycle after the push edge.
        push(6'b000101);
        e0 = cyc;
        wait_issue("t1_issue", 10, t);
        check("t1_latency", t, e0 + 1);
        check("t1_instr", {26'd0, issue_instr}, 32'b000101);
        wait_idle("t1_idle", 20);
        exp_done = 1;
        check("t1_done", {16'd0, done_count}, exp_done);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Fill with the controller held busy; the ninth push must be dropped.
        force_busy = 1'b1;
        tick(2);
        host_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            host_instr = IW'(i * 7 + 3);
            tick();
            if (i == 6) check("t2_not_full", {31'd0, host_ready}, 32'd1);
            if (i == 7) check("t2_full", {31'd0, host_ready}, 32'd0);
        end
        host_valid = 1'b0;
        check("t2_count", {28'd0, fifo_count}, 32'd8);
        force_busy = 1'b0;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            wait_issue("t2_issue", 30, t);
            if (prev >= 0 && t >= 0) check("t2_spacing", t - prev, 32'd5);
            prev = t;
        end
        wait_idle("t2_idle", 20);
        exp_done += 8;
        check("t2_done", {16'd0, done_count}, exp_done);

        // Flush three queued entries while one instruction is in flight.
        busy_len = 10;
        push(6'h11);
        wait_issue("t3_issue", 10, t);
        tick();
        push(6'h12);
        push(6'h13);
        push(6'h14);
        check("t3_queued", {28'd0, fifo_count}, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flushed", {28'd0, fifo_count}, 32'd0);
        snap = n_issued;
        for (int i = 0; i < 40; i++) @(negedge clk);
        check("t3_no_issue", n_issued - snap, 32'd0);
        exp_done += 1;
        check("t3_done", {16'd0, done_count}, exp_done);
        check("t3_busy", {31'd0, busy}, 32'd0);
        tick();
        busy_len = 2;

        // Asynchronous reset during ISSUE.
        push(6'h2a);
        wait_issue("t4_issue", 10, t);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4_midreset");
        exp_done = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(4);
        push(6'h35);
        wait_issue("t4_resume", 10, t);
        check("t4_resume_instr", {26'd0, issue_instr}, 32'h35);
        wait_idle("t4_idle", 20);
        exp_done += 1;
        check("t4_done", {16'd0, done_count}, exp_done);

        // Controller never leaves idle: WAIT_BUSY watchdog.
        ignore_su = 1'b1;
        tick();
        push(6'h07);
        wait_issue("t5_issue", 10, t);
        @(negedge clk);
        @(negedge clk);
        check("t5_err_before", {31'd0, err}, 32'd0);
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t5_err", {31'd0, err}, 32'd1);
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_done", {16'd0, done_count}, exp_done);
        tick();
        ignore_su = 1'b0;

        // Reset, then a controller stuck busy for 100 cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(2);
        exp_done = 0;
        check("t6_err_cleared", {31'd0, err}, 32'd0);
        busy_len = 100;
        push(6'h21);
        push(6'h22);
        wait_issue("t6_issue", 10, t_first);
        tick();
        busy_len = 2;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 65) check("t6_err_before", {31'd0, err}, 32'd0);
            if (k == 66) begin
                check("t6_err", {31'd0, err}, 32'd1);
                check("t6_done", {16'd0, done_count}, exp_done);
            end
        end
        wait_issue("t6_next_issue", 60, t);
        if (t >= 0) check("t6_next_gap", t - t_first, 32'd102);
        wait_idle("t6_idle", 20);
        exp_done += 1;
        check("t6_done_after", {16'd0, done_count}, exp_done);

        // Random traffic with flushes and varying controller latency.
        tick();
        snap = n_issued;
        for (int i = 0; i < 400; i++) begin
            host_valid = 1'($urandom % 2);
            host_instr = IW'($urandom);
            flush      = ($urandom % 32) == 0;
            busy_len   = $urandom_range(1, 4);
            tick();
        end
        host_valid = 1'b0;
        flush      = 1'b0;
        wait_idle("t7_drain", 300);
        check("t7_model_empty", exp_q.size(), 32'd0);
        exp_done += n_issued - snap;
        check("t7_done", {16'd0, done_count}, exp_done);
        check("t7_no_err_change", {31'd0, err}, 32'd1);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
